payoff_accumulator: RTL

//   Downstream of the path generator: consumes simulated price samples, forms the European call

---
 rtl/option_pkg.sv | 22 ++
 rtl/payoff_calc.sv | 12 +
 rtl/payoff_accumulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/option_pkg.sv
// Shared constants, FSM state type and Q-format helpers for the option pricing datapath.
package option_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam logic [15:0] DISC_ONE = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Multiply an unsigned value (up to 32 bits) by a Q1.15 factor and drop the fraction (floor).
  function automatic logic [47:0] q15_scale(input logic [31:0] v, input logic [15:0] d);
    logic [47:0] p;
    p = {16'b0, v} * {32'b0, d};
    return p >> 15;
  endfunction

endpackage

// File: rtl/payoff_calc.sv
// Combinational call payoff max(S-K,0) on unsigned fixed-point operands.
module payoff_calc #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] s,
  input  logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] payoff
);

  assign payoff = (s > k) ? (s - k) : '0;

endmodule

// File: rtl/payoff_accumulator.sv
// Accumulates 2^N_PATHS_LOG2 call payoffs and emits the discounted mean as the option price.
// Optional build macro PAYOFF_ASIAN_EN selects an arithmetic-average Asian payoff.
module payoff_accumulator
  import option_pkg::*;
#(
  parameter int DATA_W       = option_pkg::DATA_W,
  parameter int N_PATHS_LOG2 = 10,
  parameter int STEPS_LOG2   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] strike,
  input  logic [15:0]       disc,
  input  logic              path_valid,
  input  logic [DATA_W-1:0] path,
  input  logic              path_last,
  output logic              busy,
  output logic              price_valid,
  output logic [DATA_W-1:0] price,
  output logic              err
);

  localparam int ACC_W = DATA_W + N_PATHS_LOG2;

  // The scaler helper is 32-bit wide on its input and averaging needs at least one step bit.
  if (DATA_W > 32 || STEPS_LOG2 < 1) begin : g_param_chk
    $error("payoff_accumulator: unsupported DATA_W/STEPS_LOG2");
  end

  state_t                  state, state_nxt;
  logic [DATA_W-1:0]       strike_q;
  logic [15:0]             disc_q;
  logic [ACC_W-1:0]        acc;
  logic [N_PATHS_LOG2-1:0] path_cnt;
  logic [DATA_W-1:0]       s_eval;
  logic [DATA_W-1:0]       payoff;
  logic                    path_done;
  logic                    last_path;
  logic [DATA_W-1:0]       mean;
  logic [47:0]             scaled;
  logic [DATA_W-1:0]       price_sat;

  assign path_done = (state == ST_ACCUM) && path_valid && path_last;
  assign last_path = path_done && (path_cnt == '1);

`ifdef PAYOFF_ASIAN_EN
  localparam int SUM_W = DATA_W + STEPS_LOG2;

  logic [SUM_W-1:0]      step_sum;
  logic [SUM_W-1:0]      sum_nxt;
  logic [STEPS_LOG2-1:0] step_cnt;
  logic                  err_q;

  assign sum_nxt = step_sum + SUM_W'(path);
  assign s_eval  = sum_nxt[SUM_W-1:STEPS_LOG2];
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sum <= '0;
      step_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        step_sum <= '0;
        step_cnt <= '0;
        err_q    <= 1'b0;
      end
    end else if (state == ST_ACCUM && path_valid) begin
      if (path_last) begin
        step_sum <= '0;
        step_cnt <= '0;
        if (step_cnt != '1) err_q <= 1'b1;
      end else begin
        step_sum <= sum_nxt;
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end
`else
  assign s_eval = path;
  assign err    = 1'b0;
`endif

  payoff_calc #(.DATA_W(DATA_W)) u_payoff_calc (
    .s      (s_eval),
    .k      (strike_q),
    .payoff (payoff)
  );

  assign mean      = acc[ACC_W-1:N_PATHS_LOG2];
  assign scaled    = q15_scale(32'(mean), disc_q);
  assign price_sat = (scaled[47:DATA_W] != '0) ? '1 : scaled[DATA_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ACCUM;
      ST_ACCUM: if (last_path) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // price_valid and the busy drop are registered off DONE, so they land together one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      strike_q    <= '0;
      disc_q      <= '0;
      acc         <= '0;
      path_cnt    <= '0;
      price       <= '0;
      busy        <= 1'b0;
      price_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      price_valid <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            strike_q <= strike;
            disc_q   <= disc;
            acc      <= '0;
            path_cnt <= '0;
            price    <= '0;
            busy     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (path_done) begin
            acc      <= acc + ACC_W'(payoff);
            path_cnt <= path_cnt + 1'b1;
          end
        end
        ST_SCALE: price <= price_sat;
        ST_DONE:  busy  <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
